// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and TX-FIFO-side signals for uart_tx_arbiter.
// The arbiter uses the slave modport; requesters and the FIFO model use master.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] wdata;
  logic [N_REQ-1:0]   last;
  logic               fifo_full;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   ack;
  logic               fifo_write;
  logic [7:0]         fifo_wdata;
  logic               busy;

  modport master (
    output req, wdata, last, fifo_full,
    input  gnt, ack, fifo_write, fifo_wdata, busy
  );

  modport slave (
    input  req, wdata, last, fifo_full,
    output gnt, ack, fifo_write, fifo_wdata, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter sharing the UART TX FIFO write port among N_REQ requesters.
// Optional macro UART_ARB_PRIO0_EN gives requester 0 fixed priority at arbitration time.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nx;
  logic [PTR_W-1:0]   cur, cur_nx;
  logic [PTR_W-1:0]   pick;
  logic               pick_valid;
  logic [PTR_W-1:0]   idx;
  logic [PTR_W-1:0]   ptr_after_cur;
  logic [7:0]         burst_cnt, burst_cnt_nx, burst_inc;
  logic [7:0]         cur_byte;
  logic               rel;

  logic [N_REQ-1:0]   gnt_q, gnt_nx;
  logic [N_REQ-1:0]   ack_q, ack_nx;
  logic               fifo_write_q, fifo_write_nx;
  logic [7:0]         fifo_wdata_q, fifo_wdata_nx;
  logic               busy_q, busy_nx;

  assign bus.gnt        = gnt_q;
  assign bus.ack        = ack_q;
  assign bus.fifo_write = fifo_write_q;
  assign bus.fifo_wdata = fifo_wdata_q;
  assign bus.busy       = busy_q;

  assign cur_byte      = bus.wdata[{cur, 3'b000} +: 8];
  assign burst_inc     = burst_cnt + 8'd1;
  assign ptr_after_cur = (cur == PTR_W'(N_REQ - 1)) ? '0 : cur + PTR_W'(1);

  // Walk downward so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      if (bus.req[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
`ifdef UART_ARB_PRIO0_EN
    if (bus.req[0]) begin
      pick       = '0;
      pick_valid = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cur          <= '0;
      burst_cnt    <= '0;
      gnt_q        <= '0;
      ack_q        <= '0;
      fifo_write_q <= 1'b0;
      fifo_wdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_nx;
      rr_ptr       <= rr_ptr_nx;
      cur          <= cur_nx;
      burst_cnt    <= burst_cnt_nx;
      gnt_q        <= gnt_nx;
      ack_q        <= ack_nx;
      fifo_write_q <= fifo_write_nx;
      fifo_wdata_q <= fifo_wdata_nx;
      busy_q       <= busy_nx;
    end
  end

  // The ack cycle is skipped so the requester can advance its byte or drop req.
  always_comb begin
    state_nx      = state;
    rr_ptr_nx     = rr_ptr;
    cur_nx        = cur;
    burst_cnt_nx  = burst_cnt;
    gnt_nx        = gnt_q;
    ack_nx        = '0;
    fifo_write_nx = 1'b0;
    fifo_wdata_nx = fifo_wdata_q;
    busy_nx       = busy_q;
    rel           = 1'b0;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nx     = XFER;
          cur_nx       = pick;
          gnt_nx       = '0;
          gnt_nx[pick] = 1'b1;
          busy_nx      = 1'b1;
          burst_cnt_nx = '0;
        end
      end
      XFER: begin
        if (!ack_q[cur]) begin
          if (!bus.req[cur]) begin
            rel = 1'b1;
          end else if (!bus.fifo_full) begin
            fifo_write_nx = 1'b1;
            fifo_wdata_nx = cur_byte;
            ack_nx[cur]   = 1'b1;
            burst_cnt_nx  = burst_inc;
            if (bus.last[cur] || (burst_inc == 8'(MAX_BURST))) begin
              rel = 1'b1;
            end
          end
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (rel) begin
      state_nx = GAP;
      gnt_nx   = '0;
      busy_nx  = 1'b0;
`ifdef UART_ARB_PRIO0_EN
      if (cur != '0) begin
        rr_ptr_nx = ptr_after_cur;
      end
`else
      rr_ptr_nx = ptr_after_cur;
`endif
    end
  end

  assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt_q));
  assert property (@(posedge clk) disable iff (!reset) (fifo_write_q == $onehot(ack_q)));

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART TX FIFO write port among N_REQ byte-stream requesters (CPU, DMA, debug, ...).
- Sits in front of the TX FIFO, upstream of the framing/process stage.
- Grants one requester at a time with round-robin fairness.
- Holds the grant for a burst, ended by a last flag, a dropped request or MAX_BURST bytes, so messages are not interleaved mid-packet.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_BURST, 8, maximum bytes per grant before forced release (1..255)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
req  input  N_REQ  per-requester request; held high while a byte is presented
wdata  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
last  input  N_REQ  per-requester flag; byte presented is the last of its packet
fifo_full  input  1  TX FIFO full; no write may issue while high
gnt  output  N_REQ  one-hot current grant, all zero when idle
ack  output  N_REQ  one-cycle pulse: requester's byte was written to the FIFO
fifo_write  output  1  one-cycle FIFO write strobe
fifo_wdata  output  8  byte accompanying fifo_write
busy  output  1  high while in XFER state

Behaviour:
- Reset: synchronous, active-low; clock clk. When reset==0 at a posedge:
  - state=IDLE, rr_ptr=0, burst_cnt=0.
  - gnt=0, ack=0, fifo_write=0, fifo_wdata=0, busy=0.
  - Reset mid-burst aborts the grant. Any byte already strobed stays in the FIFO. No further ack is issued.
- All outputs are registered.
- States: IDLE, XFER, GAP.
- IDLE:
  - If any req bit is high, pick the first requester g searching circularly from rr_ptr upward.
  - Next cycle: gnt=onehot(g), busy=1, burst_cnt=0, state=XFER.
  - If no request, stay in IDLE.
- XFER capture cycle: req[g]=1, fifo_full=0, and ack[g] is not currently high. At the next edge:
  - fifo_write=1, fifo_wdata=wdata[g], ack[g]=1 (all one cycle).
  - burst_cnt increments.
- Cycle with ack high: no capture. The requester uses this cycle to advance its data or drop req. Peak throughput is therefore 1 byte per 2 cycles.
- fifo_full=1 in XFER: stall, with no write, no ack and the grant held. There is no timeout.
- Release, to GAP, happens at the edge after any of:
  - a capture with last[g]=1;
  - a capture that makes burst_cnt==MAX_BURST;
  - req[g]=0 in a non-ack cycle.
- On release:
  - gnt=0, busy=0, rr_ptr=(g+1) mod N_REQ.
  - The release edge coincides with the final ack and fifo_write pulse when triggered by a capture.
- GAP: one dead cycle, then IDLE. A new grant therefore appears no earlier than 2 cycles after release.
- Requests from non-granted requesters are ignored until arbitration. A requester dropping req while not granted is legal.
- Simultaneous requests are resolved strictly by rr_ptr order.
- burst_cnt is 8 bits. Its value is irrelevant in IDLE and GAP.
- gnt is never multi-hot. fifo_write is never high while fifo_full was high on the capture cycle.

Optional Feature:
UART_ARB_PRIO0_EN:
- Defined:
  - Requester 0 is high priority. In IDLE, req[0] wins regardless of rr_ptr.
  - A grant to requester 0 does not advance rr_ptr.
  - Requester 0 still obeys the last, MAX_BURST and drop release rules. It cannot preempt an active burst.
- Undefined: pure round-robin as above.

Test Plan:
1. Reset, then req=4'b0001, wdata0=8'hA5, last0=1.
   -> gnt=0001 one cycle later. fifo_write with 8'hA5 and ack[0] pulse one cycle after that. gnt=0 at the same edge; rr_ptr=1.
2. req=4'b1111, each sends one byte with last=1, rr_ptr=0.
   -> grants in order 0,1,2,3. Gap cycle between each. FIFO receives bytes in that order.
3. Requester 2 streams 12 bytes 8'h00..8'h0B with last=0, MAX_BURST=8.
   -> 8 writes (00..07), then forced release.
   -> Regrant of 2 only after the other pending requesters are served. Remaining 4 bytes then follow.
4. fifo_full=1 for 5 cycles during a granted burst.
   -> no fifo_write and no ack during the stall. Grant held. The write occurs the cycle after fifo_full falls.
5. reset=0 asserted mid-burst after 3 bytes.
   -> next edge: all outputs 0, state IDLE.
   -> After release, requester 0 is granted first (rr_ptr=0).
6. With UART_ARB_PRIO0_EN: rr_ptr=2, req=4'b0101.
   -> requester 0 is granted first and rr_ptr stays 2. Requester 2 is granted next.
   -> Without the macro, requester 2 is granted first.
